// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default layer geometry and width helper for the conv layer blocks.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, CAPT, HOLD, DONE} conv_seq_state_t;
  localparam int NON_ZERO_WEIGHTS_DEF = 27;
  localparam int SETUP_CYCLES_DEF = 7;
  localparam int PE_LATENCY_DEF = 2;
  function automatic int clog2_min1(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/conv_layer_seq_ctrl_if.sv
// conv_layer_seq_ctrl_if: sequencer control/handshake bundle; CONV_SEQ_STALL_CNT_EN adds stall_cycles.
interface conv_layer_seq_ctrl_if #(parameter int IDX_W = 5, parameter int PASS_W = 1);
  logic start;
  logic out_ready;
  logic busy;
  logic weight_valid;
  logic [IDX_W-1:0] weight_index;
  logic pe_clear;
  logic capture;
  logic out_valid;
  logic [PASS_W-1:0] pass_index;
  logic done;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
  modport master(input start, out_ready, output busy, weight_valid, weight_index, pe_clear, capture,
                 out_valid, pass_index, done, stall_cycles);
  modport slave(output start, out_ready, input busy, weight_valid, weight_index, pe_clear, capture,
                out_valid, pass_index, done, stall_cycles);
`else
  modport master(input start, out_ready, output busy, weight_valid, weight_index, pe_clear, capture,
                 out_valid, pass_index, done);
  modport slave(output start, out_ready, input busy, weight_valid, weight_index, pe_clear, capture,
                out_valid, pass_index, done);
`endif
endinterface

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter that stops at zero and flags its terminal count.
module seq_down_counter #(parameter int W = 3) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/conv_layer_seq_ctrl.sv
// conv_layer_seq_ctrl: setup/stream/drain/capture/hold sequencer for one conv layer.
// Optional CONV_SEQ_STALL_CNT_EN counts HOLD cycles stalled by out_ready.
module conv_layer_seq_ctrl
  import conv_pkg::*;
#(
  parameter int NON_ZERO_WEIGHTS = NON_ZERO_WEIGHTS_DEF,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int PE_LATENCY = PE_LATENCY_DEF,
  parameter int NUM_PASSES = 1,
  parameter int IDX_W = clog2_min1(NON_ZERO_WEIGHTS),
  parameter int PASS_W = clog2_min1(NUM_PASSES)
) (
  input logic clk,
  input logic rst,
  conv_layer_seq_ctrl_if.master bus
);
  localparam int SL = SETUP_CYCLES > 0 ? SETUP_CYCLES - 1 : 0;
  localparam int DL = PE_LATENCY > 0 ? PE_LATENCY - 1 : 0;
  localparam int TW = clog2_min1(SETUP_CYCLES > PE_LATENCY ? SETUP_CYCLES : PE_LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NON_ZERO_WEIGHTS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
  conv_seq_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic busy_q, busy_d, wv_q, wv_d, pc_q, pc_d, cap_q, cap_d, ov_q, ov_d, done_q, done_d;
  logic tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  seq_down_counter #(.W(TW)) u_tmr (
    .clk(clk), .rst(rst), .load(tmr_load), .dec(tmr_dec), .load_val(tmr_val), .zero(tmr_zero)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pass_d = pass_q;
    tmr_load = 1'b0;
    tmr_val = '0;
    case (state_q)
      IDLE: if (bus.start) begin
        pass_d = '0;
        state_d = SETUP_CYCLES == 0 ? STREAM : SETUP;
        tmr_load = 1'b1;
        tmr_val = TW'(SL);
      end
      SETUP: state_d = tmr_zero ? STREAM : SETUP;
      STREAM: begin
        idx_d = idx_q == LAST_IDX ? '0 : idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = PE_LATENCY == 0 ? CAPT : DRAIN;
          tmr_load = 1'b1;
          tmr_val = TW'(DL);
        end
      end
      DRAIN: state_d = tmr_zero ? CAPT : DRAIN;
      CAPT: state_d = HOLD;
      HOLD: if (bus.out_ready) begin
        state_d = pass_q == LAST_PASS ? DONE : STREAM;
        pass_d = pass_q == LAST_PASS ? pass_q : pass_q + PASS_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tmr_dec = state_q == SETUP || state_q == DRAIN;
    busy_d = state_d != IDLE;
    wv_d = state_d == STREAM;
    pc_d = state_d == STREAM && idx_d == '0;
    cap_d = state_d == CAPT;
    ov_d = state_d == HOLD;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      pass_q <= '0;
      {busy_q, wv_q, pc_q, cap_q, ov_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pass_q <= pass_d;
      {busy_q, wv_q, pc_q, cap_q, ov_q, done_q} <= {busy_d, wv_d, pc_d, cap_d, ov_d, done_d};
    end
  end
  assign bus.busy = busy_q;
  assign bus.weight_valid = wv_q;
  assign bus.weight_index = idx_q;
  assign bus.pe_clear = pc_q;
  assign bus.capture = cap_q;
  assign bus.out_valid = ov_q;
  assign bus.pass_index = pass_q;
  assign bus.done = done_q;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (state_q == IDLE && bus.start) ? '0 :
                        (state_q == HOLD && !bus.out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_conv_layer_seq_ctrl.sv
// tb_conv_layer_seq_ctrl: directed bench over default, three-pass and minimal-geometry sequencers.
module tb_conv_layer_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  conv_layer_seq_ctrl_if #(.IDX_W(5), .PASS_W(1)) b0 ();
  conv_layer_seq_ctrl_if #(.IDX_W(5), .PASS_W(2)) b1 ();
  conv_layer_seq_ctrl_if #(.IDX_W(1), .PASS_W(1)) b2 ();
  conv_layer_seq_ctrl u0 (.clk(clk), .rst(rst), .bus(b0));
  conv_layer_seq_ctrl #(.NUM_PASSES(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
  conv_layer_seq_ctrl #(.NON_ZERO_WEIGHTS(1), .SETUP_CYCLES(0), .PE_LATENCY(0)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({b0.busy, b0.weight_valid, b0.weight_index, b0.pe_clear, b0.capture, b0.out_valid, b0.pass_index, b0.done} !== '0) begin
      errors++;
      $display("FAIL reset_u0 got busy=%b wv=%b idx=%0d ov=%b done=%b want all 0", b0.busy, b0.weight_valid, b0.weight_index, b0.out_valid, b0.done);
    end
    checks++;
    if ({b1.busy, b1.weight_valid, b1.pass_index, b1.capture, b1.out_valid, b1.done} !== '0) begin
      errors++;
      $display("FAIL reset_u1 got busy=%b pass=%0d want all 0", b1.busy, b1.pass_index);
    end
    checks++;
    if ({b2.busy, b2.weight_valid, b2.pe_clear, b2.capture, b2.out_valid, b2.done} !== '0) begin
      errors++;
      $display("FAIL reset_u2 got busy=%b wv=%b want all 0", b2.busy, b2.weight_valid);
    end
`ifdef CONV_SEQ_STALL_CNT_EN
    checks++;
    if (b0.stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", b0.stall_cycles);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_run(input int h);
    logic [5:0] exp;
    logic [4:0] eidx;
    @(negedge clk);
    b0.start = 1'b1;
    b0.out_ready = (h == 0);
    for (int k = 1; k <= 41 + h; k++) begin
      @(negedge clk);
      b0.start = 1'b0;
      exp = {k <= 39 + h, k >= 8 && k <= 34, k == 8, k == 37, k >= 38 && k <= 38 + h, k == 39 + h};
      eidx = (k >= 8 && k <= 34) ? 5'(k - 8) : 5'd0;
      checks++;
      if ({b0.busy, b0.weight_valid, b0.pe_clear, b0.capture, b0.out_valid, b0.done, b0.weight_index} !== {exp, eidx}) begin
        errors++;
        $display("FAIL run_h%0d cycle %0d got bwpcod=%b idx=%0d want %b idx=%0d", h, k,
                 {b0.busy, b0.weight_valid, b0.pe_clear, b0.capture, b0.out_valid, b0.done}, b0.weight_index, exp, eidx);
      end
      b0.out_ready = (h == 0) || (k >= 38 + h);
    end
`ifdef CONV_SEQ_STALL_CNT_EN
    checks++;
    if (b0.stall_cycles !== 16'(h)) begin
      errors++;
      $display("FAIL stall_cycles got %0d want %0d", b0.stall_cycles, h);
    end
`endif
  endtask

  task automatic test_multi_pass();
    int cap_cyc[3];
    int cap_pass[3];
    int ncap = 0, ndone = 0, done_cyc = -1, nbusy = 0, nwv = 0, first_wv = -1;
    @(negedge clk);
    b1.start = 1'b1;
    b1.out_ready = 1'b1;
    for (int k = 1; k <= 106; k++) begin
      @(negedge clk);
      b1.start = 1'b0;
      if (b1.capture) begin
        if (ncap < 3) begin
          cap_cyc[ncap] = k;
          cap_pass[ncap] = int'(b1.pass_index);
        end
        ncap++;
      end
      if (b1.done) begin
        ndone++;
        done_cyc = k;
      end
      if (b1.busy) nbusy++;
      if (b1.weight_valid) begin
        nwv++;
        if (first_wv < 0) first_wv = k;
      end
    end
    checks++;
    if (ncap != 3) begin
      errors++;
      $display("FAIL mp_ncap got %0d want 3", ncap);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap_cyc[i] != 37 + 31 * i || cap_pass[i] != i) begin
          errors++;
          $display("FAIL mp_capture%0d got cycle %0d pass %0d want cycle %0d pass %0d", i, cap_cyc[i], cap_pass[i], 37 + 31 * i, i);
        end
      end
    end
    checks++;
    if (ndone != 1 || done_cyc != 101) begin
      errors++;
      $display("FAIL mp_done got count %0d at %0d want 1 at 101", ndone, done_cyc);
    end
    checks++;
    if (nbusy != 101 || nwv != 81 || first_wv != 8) begin
      errors++;
      $display("FAIL mp_timing got busy %0d wv %0d first_wv %0d want 101 81 8", nbusy, nwv, first_wv);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    b0.start = 1'b1;
    b0.out_ready = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      b0.start = 1'b0;
    end
    checks++;
    if (b0.weight_index !== 5'd10 || b0.weight_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrun_idx got %0d wv %b want 10 1", b0.weight_index, b0.weight_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b0.busy, b0.weight_valid, b0.weight_index, b0.pe_clear, b0.capture, b0.out_valid, b0.pass_index, b0.done} !== '0) begin
      errors++;
      $display("FAIL midrun_abort got busy=%b wv=%b idx=%0d cap=%b done=%b want all 0", b0.busy, b0.weight_valid, b0.weight_index, b0.capture, b0.done);
    end
    rst = 1'b0;
    test_single_run(0);
  endtask

  task automatic test_tiny();
    logic [5:0] exp_t [5] = '{6'b111000, 6'b100100, 6'b100010, 6'b100001, 6'b000000};
    @(negedge clk);
    b2.start = 1'b1;
    b2.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      b2.start = 1'b0;
      checks++;
      if ({b2.busy, b2.weight_valid, b2.pe_clear, b2.capture, b2.out_valid, b2.done} !== exp_t[k-1] || b2.weight_index !== 1'b0) begin
        errors++;
        $display("FAIL tiny cycle %0d got %b idx %0d want %b idx 0", k,
                 {b2.busy, b2.weight_valid, b2.pe_clear, b2.capture, b2.out_valid, b2.done}, b2.weight_index, exp_t[k-1]);
      end
    end
  endtask

  task automatic test_start_held();
    logic [2:0] exp;
    @(negedge clk);
    b0.start = 1'b1;
    b0.out_ready = 1'b1;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      if (k >= 41) b0.start = 1'b0;
      exp = {(k <= 39) || (k >= 41 && k <= 79), (k >= 8 && k <= 34) || (k >= 48 && k <= 74), k == 39 || k == 79};
      checks++;
      if ({b0.busy, b0.weight_valid, b0.done} !== exp) begin
        errors++;
        $display("FAIL start_held cycle %0d got bwd=%b want %b", k, {b0.busy, b0.weight_valid, b0.done}, exp);
      end
    end
  endtask

  initial begin
    {b0.start, b0.out_ready, b1.start, b1.out_ready, b2.start, b2.out_ready} = '0;
    test_reset();
    test_single_run(0);
    test_multi_pass();
    test_single_run(5);
    test_reset_midrun();
    test_tiny();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
